// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute controller for the 8-bit CPU.
// Owns pc and ir and sequences FETCH, WAIT, EXEC, WB, with HALT as a sticky stop.
// Ports:
//   clk, rst (sync, active-low), run: clock, reset, run/pause level
//   rom_enable/rom_addr/rom_data: ROM read port; data valid one cycle after enable
//   ir: latched instruction for the decoder
//   dec_halt/dec_jump/dec_jump_target/dec_gpr_we: decoder status inputs
//   gpr_w_enable: gated GPR write strobe
//   pc, halted, retire: status outputs
// Optional: CPU_SEQUENCER_SINGLE_STEP_EN adds a 'step' input for single-instruction runs.
module cpu_sequencer #(
  parameter int unsigned          PC_WIDTH    = 8,
  parameter int unsigned          INSTR_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  input  logic                   step,
`endif
  output logic                   rom_enable,
  output logic [PC_WIDTH-1:0]    rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [INSTR_WIDTH-1:0] ir,
  input  logic                   dec_halt,
  input  logic                   dec_jump,
  input  logic [PC_WIDTH-1:0]    dec_jump_target,
  input  logic                   dec_gpr_we,
  output logic                   gpr_w_enable,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic                   retire
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   rom_enable_q;
  logic                   halted_q;
  logic                   retire_q;
  logic                   step_mode_q, step_mode_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    step_mode_d = step_mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
`endif
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // halt wins over jump and writeback
        if (dec_halt) state_d = S_HALT;
        else          state_d = S_WB;
      end
      S_WB: begin
        pc_d = dec_jump ? dec_jump_target : pc_q + PC_WIDTH'(1);
        // a stepped instruction always drops back to IDLE
        if (step_mode_q) begin
          state_d     = S_IDLE;
          step_mode_d = 1'b0;
        end else if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // strobes are registered off the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      step_mode_q  <= 1'b0;
      rom_enable_q <= 1'b0;
      halted_q     <= 1'b0;
      retire_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      step_mode_q  <= step_mode_d;
      rom_enable_q <= (state_d == S_FETCH);
      halted_q     <= (state_d == S_HALT);
      retire_q     <= (state_d == S_WB);
    end
  end

  assign rom_enable   = rom_enable_q;
  assign rom_addr     = pc_q;
  assign ir           = ir_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign retire       = retire_q;
  assign gpr_w_enable = (state_q == S_WB) & dec_gpr_we;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: ROM model, tiny decoder, vector table,
// ir scoreboard and hand-written corner sequences.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic        rom_enable;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] ir;
  logic        dec_halt;
  logic        dec_jump;
  logic [7:0]  dec_jump_target;
  logic        dec_gpr_we;
  logic        gpr_w_enable;
  logic [7:0]  pc;
  logic        halted;
  logic        retire;

  cpu_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    .step            (step),
`endif
    .rom_enable      (rom_enable),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .ir              (ir),
    .dec_halt        (dec_halt),
    .dec_jump        (dec_jump),
    .dec_jump_target (dec_jump_target),
    .dec_gpr_we      (dec_gpr_we),
    .gpr_w_enable    (gpr_w_enable),
    .pc              (pc),
    .halted          (halted),
    .retire          (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ROM: registered read, data valid the cycle after rom_enable
  logic [23:0] mem [256];
  logic [23:0] exp_q [$];

  always @(posedge clk) begin
    if (rom_enable) begin
      rom_data <= mem[rom_addr];
      exp_q.push_back(mem[rom_addr]);
    end
  end

  // on retire, ir must be the word fetched for this instruction
  always @(negedge clk) begin
    if (retire) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        check("sb_ir", 64'(ir), 64'(exp_q.pop_front()));
      end
    end
  end

  // decoder: FF=halt, EE=jump to ir[7:0], any nonzero opcode writes a GPR
  logic       dec_rand_en;
  logic [3:0] rnd;
  logic [7:0] rnd_tgt;
  logic [7:0] op;

  always_comb begin
    op = ir[23:16];
    if (dec_rand_en) begin
      dec_halt        = rnd[0];
      dec_jump        = rnd[1];
      dec_gpr_we      = rnd[2];
      dec_jump_target = rnd_tgt;
    end else begin
      dec_halt        = (op == 8'hFF);
      dec_jump        = (op == 8'hEE);
      dec_gpr_we      = (op != 8'h00);
      dec_jump_target = ir[7:0];
    end
  end

  typedef struct {
    logic        re;
    logic [7:0]  addr;
    logic        gwe;
    logic        ret;
    logic [23:0] ir;
  } vec_t;

  vec_t tbl [12];

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic wait_rom(input string name, input logic [7:0] exp_addr);
    int k;
    k = 0;
    while (!rom_enable && k < 12) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!rom_enable) check({name, "_timeout"}, 64'd0, 64'd1);
    else             check(name, 64'(rom_addr), 64'(exp_addr));
    @(posedge clk);
    #1;
  endtask

  int rcnt;
  int ecnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
    mem[0]    = 24'h110203;
    mem[1]    = 24'h220304;
    mem[2]    = 24'h330405;
    mem[5]    = 24'hEE00FF;
    mem[8'hFF] = 24'h440000;
    rom_data  = '0;
    step      = 1'b0;
    run       = 1'b1;
    rst       = 1'b0;
    dec_rand_en = 1'b1;
    rnd       = 4'hF;
    rnd_tgt   = 8'hA5;

    for (int c = 0; c < 12; c++) begin
      automatic logic [23:0] w;
      w = 24'h000000;
      if (c >= 2 && c < 6)  w = 24'h110203;
      if (c >= 6 && c < 10) w = 24'h220304;
      if (c >= 10)          w = 24'h330405;
      tbl[c].re   = (c % 4 == 0);
      tbl[c].addr = 8'(c / 4);
      tbl[c].gwe  = (c % 4 == 3);
      tbl[c].ret  = (c % 4 == 3);
      tbl[c].ir   = w;
    end

    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("reset_outs",
            64'({rom_enable, gpr_w_enable, halted, retire, pc, ir}),
            64'(0));
      rnd     = 4'($urandom_range(0, 15));
      rnd_tgt = 8'($urandom_range(0, 255));
    end
    exp_q.delete();
    dec_rand_en = 1'b0;
    rst = 1'b1;

    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("line_c%0d", c + 1),
            64'({rom_enable, rom_addr, gpr_w_enable, retire, ir}),
            64'({tbl[c].re, tbl[c].addr, tbl[c].gwe, tbl[c].ret, tbl[c].ir}));
    end
    @(posedge clk);
    #1;
    check("pc_after_3", 64'(pc), 64'd3);

    wait_rom("addr_3", 8'h03);
    wait_rom("addr_4", 8'h04);
    wait_rom("addr_5", 8'h05);
    wait_rom("jump_ff", 8'hFF);
    wait_rom("wrap_00", 8'h00);

    mem[0] = 24'hFF0000;
    do_reset(2);
    rst = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("pre_halt_gwe", 64'(gpr_w_enable), 64'd0);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("halt_hold",
            64'({halted, gpr_w_enable, rom_enable, retire, pc}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
      run = ~run;
    end
    do_reset(1);
    check("halt_reset", 64'({halted, pc, ir}), 64'(0));

    mem[0] = 24'h110203;
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    run  = 1'b0;
    rcnt = 0;
    ecnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (retire) rcnt++;
      if (rom_enable) ecnt++;
    end
    check("pause_retires", 64'(rcnt), 64'd1);
    check("pause_no_fetch", 64'(ecnt), 64'd0);
    check("pause_pc", 64'({halted, pc}), 64'({1'b0, 8'h01}));

    do_reset(2);
    rst = 1'b1;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midop_reset",
          64'({gpr_w_enable, retire, rom_enable, pc, ir}), 64'(0));
    exp_q.delete();
    rst = 1'b1;
    run = 1'b0;
    ecnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rom_enable || gpr_w_enable) ecnt++;
    end
    check("midop_idle", 64'(ecnt), 64'd0);

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    rcnt = 0;
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        if (retire) rcnt++;
      end
      check($sformatf("step_pc_%0d", s), 64'(pc), 64'(s + 1));
    end
    check("step_retires", 64'(rcnt), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 8-bit CPU; replaces the constant ROM enable in the top level.
- Owns the program counter and the instruction register, and sequences ROM fetch, decode, and GPR writeback.
- The decoder and ALU stay combinational and read `ir`. Decoder status flags steer the program counter and gate the GPR write strobe.
- Sits between rom, decoder and gpr inside top.

Parameters:
- PC_WIDTH, 8, program counter / ROM address width
- INSTR_WIDTH, 24, instruction width (3 bytes)
- RESET_PC, 0, program counter value after reset

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- run  input  1  level; 1 = execute continuously, 0 = pause at the next instruction boundary
- rom_enable  output  1  ROM read strobe
- rom_addr  output  PC_WIDTH  ROM read address (= pc)
- rom_data  input  INSTR_WIDTH  ROM read data, valid the cycle after rom_enable
- ir  output  INSTR_WIDTH  latched instruction, fed to decoder
- dec_halt  input  1  decoder: current ir is HALT
- dec_jump  input  1  decoder: current ir is a taken jump
- dec_jump_target  input  PC_WIDTH  decoder: jump destination
- dec_gpr_we  input  1  decoder: instruction writes a GPR
- gpr_w_enable  output  1  gated GPR write strobe
- pc  output  PC_WIDTH  current program counter
- halted  output  1  sequencer in HALT
- retire  output  1  one-cycle pulse per completed instruction

Behaviour:
- Reset: clk rising edge with rst=0. Values after reset:
  - state=IDLE, pc=RESET_PC, ir=0
  - rom_enable=0, gpr_w_enable=0, halted=0, retire=0
  - Reset overrides every state, including mid-instruction; no partial write escapes.
- States, 3-bit encoding: IDLE=0, FETCH=1, WAIT=2, EXEC=3, WB=4, HALT=5. Unused encodings go to IDLE.
- IDLE: all strobes 0. Goes to FETCH when run=1, otherwise stays.
- FETCH: rom_enable=1, rom_addr=pc. Always goes to WAIT.
- WAIT: rom_enable=0. ir <= rom_data at the end of the cycle. Goes to EXEC.
- EXEC: decoder/ALU settle on ir; no strobes.
  - dec_halt=1 goes to HALT; dec_halt takes priority over dec_jump and dec_gpr_we.
  - Otherwise goes to WB.
- WB:
  - gpr_w_enable = dec_gpr_we, combinational, asserted in this state only.
  - retire=1.
  - pc <= dec_jump ? dec_jump_target : pc+1, with modulo 2^PC_WIDTH wrap (255 -> 0).
  - Goes to FETCH if run=1, else IDLE.
- HALT: halted=1, all strobes 0, pc and ir frozen. Exits only via reset; run is ignored.
- Throughput: 4 cycles per instruction (FETCH, WAIT, EXEC, WB).
- Latency: first rom_enable appears the cycle after run is sampled 1 in IDLE.
- run deasserted mid-instruction: the current instruction completes through WB, then the sequencer enters IDLE. rom_enable is never asserted after WB while run=0.
- run is sampled only in IDLE and WB.
- rom_addr is driven as pc in all states; rom_enable alone qualifies it.
- gpr_w_enable is never high outside WB. In WB it is at most 1 cycle per instruction.
- ir holds its value between WAIT captures.

Optional Feature:
- Macro: CPU_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Adds input port `step` (1 bit).
  - In IDLE with run=0, a 1-cycle step=1 starts exactly one instruction (FETCH through WB), then returns to IDLE regardless of run.
  - step is ignored outside IDLE, and in IDLE when run=1.
- When undefined: no step port; IDLE leaves only on run=1.

Test Plan:
- Reset: hold rst=0 for 2 cycles with run=1 and random decoder inputs -> pc=0, ir=0, rom_enable=0, gpr_w_enable=0, halted=0, state=IDLE.
- Straight-line: release rst, run=1, ROM[0..2]=0x110203/0x220304/0x330405, dec_gpr_we=1, no jumps.
  - rom_enable pulses at cycles 1, 5, 9 with rom_addr 0, 1, 2.
  - ir=0x110203 from cycle 3.
  - gpr_w_enable and retire high at cycles 4, 8, 12.
  - pc=3 after the third WB.
- Jump and wrap:
  - dec_jump=1, dec_jump_target=0xFF at pc=0x05 -> next rom_addr=0xFF.
  - A non-jump at 0xFF -> pc wraps to 0x00.
- Halt: dec_halt=1 and dec_gpr_we=1 at EXEC -> no gpr_w_enable, halted=1 held for 20 cycles with run toggling, pc frozen.
  - rst=0 -> halted=0, pc=0.
- Pause and reset mid-op:
  - run=0 during WAIT -> instruction retires, then IDLE with no further rom_enable.
  - rst=0 asserted in EXEC -> no gpr_w_enable, state IDLE.
- Single step (macro defined): run=0, step pulses twice 10 cycles apart -> exactly two retire pulses, pc advances 0 -> 1 -> 2. With run=1, step has no effect.
